sprite_draw: RTL and testbench
==============================

SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 SHALL have ports, in this order: clk in 1 (system clock); res in 1 (synchronous, active-low reset); hires in 1 (1 = 128x64 mode, 0 = 64x32 mode); start in 1 (draw request); x in 7 (sprite X); y in 6 (sprite Y); n in 4 (row count, 0 = large sprite); sprite_addr in 12 (first sprite byte); mem_addr out 12; mem_rd out 1; mem_data in 8; fb_addr out 9; fb_rd out 1; fb_rdata in 16; fb_we out 1; fb_wdata out 16; busy out 1; done out 1; collision out 1.
REQ-002 SHALL use one clock, clk; all state changes on its rising edge; res is synchronous and active-low.
REQ-003 SHALL treat the framebuffer as 64 rows x 8 words x 16 bits; fb_addr = {row[5:0], word[2:0]}; word bit 15 = leftmost pixel (same layout the display stage scans).
REQ-004 SHALL assume mem_data and fb_rdata are valid exactly one cycle after the mem_rd or fb_rd pulse.

Function
REQ-005 SHALL accept start only in IDLE; start while busy is ignored; x, y, n, sprite_addr and hires are latched on acceptance.
REQ-006 SHALL wrap start coordinates: hires px = x mod 128, py = y mod 64; lores px = 2*(x mod 64), py = 2*(y mod 32).
REQ-007 SHALL define rows and pattern: n!=0 -> n rows of 1 byte (8 px); n=0 and hires -> 16 rows of 2 bytes (16 px, first byte left); n=0 and lores -> 16 rows of 1 byte.
REQ-008 SHALL, in lores, double each pattern bit horizontally (8 -> 16 px) and write each sprite row to framebuffer rows py+2r and py+2r+1.
REQ-009 SHALL clip and not wrap pixels: framebuffer rows >= 64 are skipped; pixels beyond column 127 are dropped.
REQ-010 SHALL, per row, form {pattern left-justified in 16 bits, 16'h0} >> px[3:0]; upper half targets word px[6:4], lower half targets word px[6:4]+1; a half whose mask is zero, or whose word index is > 7, is skipped.
REQ-011 SHALL use this FSM, one cycle per state: IDLE; FETCH (mem_rd=1, mem_addr = sprite_addr + byte index, 12-bit wrap); FWAIT (capture mem_data, then FETCH again if a second byte is needed); RD (fb_rd=1); WR (fb_we=1, fb_wdata = fb_rdata ^ mask); NEXT (advance word, framebuffer row, or sprite row); DONE.
REQ-012 SHALL skip NEXT as a separate cycle: the advance decision is made combinationally in WR, or in FWAIT when a row has no writable word; the next state is RD, FETCH or DONE.
REQ-013 SHALL set collision to 1 if any (fb_rdata & mask) != 0 during the operation; collision clears on acceptance of start and holds its value after done.
REQ-014 SHALL hold busy high from the cycle after start acceptance until DONE; in DONE, done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-015 SHALL keep mem_rd, fb_rd and fb_we low outside their states; these strobes are never asserted together.

Reset
REQ-016 SHALL, when res=0 at a clock edge, force IDLE and drive busy, done, collision, mem_rd, fb_rd and fb_we to 0, and mem_addr, fb_addr and fb_wdata to 0, including mid-draw; a partially drawn sprite is left as written.
REQ-017 SHALL ignore start in the same cycle that res=0.

Verification
REQ-018 Hires, fb all 0, x=0, y=0, n=1, byte F0, start at cycle 0 -> FETCH c1, RD c3, write addr 0 data F000 at c4, done=1 at c5, collision=0.
REQ-019 Repeat REQ-018 on the resulting framebuffer -> write addr 0 data 0000, collision=1.
REQ-020 Hires, x=12, y=1, byte FF -> writes addr 8 = 000F, then addr 9 = F000; x=140 behaves identically to x=12.
REQ-021 Hires, x=124, y=62, n=3, bytes FF -> only addr 503 and addr 511 are written, each with 000F; row 64 is clipped; done asserts.
REQ-022 Lores, x=0, y=0, n=1, byte 80 -> addr 0 = C000 and addr 8 = C000; hires n=0 -> 32 mem reads and 16 rows drawn.
REQ-023 res=0 asserted during WR of a 15-row draw -> the next cycle is IDLE with all outputs 0; a new start is then accepted normally.

Source files
------------

// File: rtl/sprite_draw.sv
// Sprite blitter: fetches sprite rows from byte memory and XORs them into a
// 64x8-word framebuffer with read-modify-write, clipping at the screen edges.
module sprite_draw (
  input  logic        clk,
  input  logic        res,
  input  logic        hires,
  input  logic        start,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] sprite_addr,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [8:0]  fb_addr,
  output logic        fb_rd,
  input  logic [15:0] fb_rdata,
  output logic        fb_we,
  output logic [15:0] fb_wdata,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [2:0] {IDLE, FETCH, FWAIT, RD, WR, DONE} state_t;

  state_t      state;
  logic        hires_r;
  logic        wide;
  logic [6:0]  px;
  logic [5:0]  py;
  logic [4:0]  rows;
  logic [11:0] base;
  logic [4:0]  row_idx;
  logic        byte_sel;
  logic        sub;
  logic        half;
  logic [7:0]  byte0_r;
  logic [7:0]  byte1_r;

  logic [7:0]  cur_b0;
  logic [7:0]  cur_b1;
  logic [15:0] pattern;
  logic [31:0] shifted;
  logic [15:0] mask_hi;
  logic [15:0] mask_lo;
  logic [2:0]  word_hi;
  logic [2:0]  word_lo;
  logic        hi_ok;
  logic        lo_ok;
  logic [6:0]  cur_fb_row;
  logic [6:0]  sub_row;
  logic        sub_ok;
  logic [4:0]  next_r;
  logic [6:0]  next_row_start;
  logic        next_row_ok;
  logic [11:0] next_idx;
  logic [15:0] cur_mask;
  logic        hit;

  // In FWAIT the byte being fetched is still on mem_data, so the masks are
  // formed from it directly to decide the next step in the same cycle.
  always_comb begin
    cur_b0 = byte0_r;
    cur_b1 = byte1_r;
    if (state == FWAIT) begin
      if (byte_sel) cur_b1 = mem_data;
      else          cur_b0 = mem_data;
    end
    pattern = {cur_b0, 8'h00};
    if (!hires_r) begin
      for (int i = 0; i < 8; i++) begin
        pattern[2*i]   = cur_b0[i];
        pattern[2*i+1] = cur_b0[i];
      end
    end else if (wide) begin
      pattern = {cur_b0, cur_b1};
    end
  end

  assign shifted  = {pattern, 16'h0000} >> px[3:0];
  assign mask_hi  = shifted[31:16];
  assign mask_lo  = shifted[15:0];
  assign word_hi  = px[6:4];
  assign word_lo  = px[6:4] + 3'd1;
  assign hi_ok    = |mask_hi;
  assign lo_ok    = (|mask_lo) && (px[6:4] != 3'd7);

  assign cur_fb_row = hires_r ? ({1'b0, py} + {2'b00, row_idx})
                              : ({1'b0, py} + {1'b0, row_idx, 1'b0} + {6'b0, sub});
  assign sub_row    = cur_fb_row + 7'd1;
  assign sub_ok     = !hires_r && !sub && (sub_row < 7'd64);

  // Screen rows only grow with the sprite row, so the first clipped row ends the draw.
  assign next_r         = row_idx + 5'd1;
  assign next_row_start = hires_r ? ({1'b0, py} + {2'b00, next_r})
                                  : ({1'b0, py} + {1'b0, next_r, 1'b0});
  assign next_row_ok    = (next_r < rows) && (next_row_start < 7'd64);
  assign next_idx       = wide ? {6'b0, next_r, 1'b0} : {7'b0, next_r};

  assign cur_mask = half ? mask_lo : mask_hi;
  // fb_rdata only arrives in the WR cycle itself, so the write data is combinational.
  assign fb_wdata = (state == WR) ? (fb_rdata ^ cur_mask) : 16'h0000;
  assign hit      = (state == WR) && (|(fb_rdata & cur_mask));

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      mem_rd    <= 1'b0;
      fb_rd     <= 1'b0;
      fb_we     <= 1'b0;
      mem_addr  <= 12'h000;
      fb_addr   <= 9'h000;
      hires_r   <= 1'b0;
      wide      <= 1'b0;
      px        <= 7'd0;
      py        <= 6'd0;
      rows      <= 5'd0;
      base      <= 12'h000;
      row_idx   <= 5'd0;
      byte_sel  <= 1'b0;
      sub       <= 1'b0;
      half      <= 1'b0;
      byte0_r   <= 8'h00;
      byte1_r   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hires_r   <= hires;
            wide      <= hires && (n == 4'd0);
            px        <= hires ? x : {x[5:0], 1'b0};
            py        <= hires ? y : {y[4:0], 1'b0};
            rows      <= (n == 4'd0) ? 5'd16 : {1'b0, n};
            base      <= sprite_addr;
            row_idx   <= 5'd0;
            byte_sel  <= 1'b0;
            sub       <= 1'b0;
            half      <= 1'b0;
            collision <= 1'b0;
            busy      <= 1'b1;
            mem_addr  <= sprite_addr;
            mem_rd    <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          mem_rd <= 1'b0;
          state  <= FWAIT;
        end
        FWAIT: begin
          if (byte_sel) byte1_r <= mem_data;
          else          byte0_r <= mem_data;
          if (wide && !byte_sel) begin
            byte_sel <= 1'b1;
            mem_addr <= mem_addr + 12'd1;
            mem_rd   <= 1'b1;
            state    <= FETCH;
          end else if (hi_ok) begin
            half    <= 1'b0;
            fb_addr <= {cur_fb_row[5:0], word_hi};
            fb_rd   <= 1'b1;
            state   <= RD;
          end else if (lo_ok) begin
            half    <= 1'b1;
            fb_addr <= {cur_fb_row[5:0], word_lo};
            fb_rd   <= 1'b1;
            state   <= RD;
          end else if (next_row_ok) begin
            row_idx  <= next_r;
            sub      <= 1'b0;
            half     <= 1'b0;
            byte_sel <= 1'b0;
            mem_addr <= base + next_idx;
            mem_rd   <= 1'b1;
            state    <= FETCH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RD: begin
          fb_rd <= 1'b0;
          fb_we <= 1'b1;
          state <= WR;
        end
        WR: begin
          fb_we <= 1'b0;
          if (hit) collision <= 1'b1;
          if (!half && lo_ok) begin
            half    <= 1'b1;
            fb_addr <= {cur_fb_row[5:0], word_lo};
            fb_rd   <= 1'b1;
            state   <= RD;
          end else if (sub_ok) begin
            // Lores rows are drawn twice; the duplicate row reuses the same masks.
            sub     <= 1'b1;
            half    <= !hi_ok;
            fb_addr <= {sub_row[5:0], hi_ok ? word_hi : word_lo};
            fb_rd   <= 1'b1;
            state   <= RD;
          end else if (next_row_ok) begin
            row_idx  <= next_r;
            sub      <= 1'b0;
            half     <= 1'b0;
            byte_sel <= 1'b0;
            mem_addr <= base + next_idx;
            mem_rd   <= 1'b1;
            state    <= FETCH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: a pixel-level screen model predicts every
// framebuffer write, which is queued and matched against the DUT's writes.
module tb_sprite_draw;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        hires = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  x = 7'd0;
  logic [5:0]  y = 6'd0;
  logic [3:0]  n = 4'd0;
  logic [11:0] sprite_addr = 12'h000;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [8:0]  fb_addr;
  logic        fb_rd;
  logic [15:0] fb_rdata;
  logic        fb_we;
  logic [15:0] fb_wdata;
  logic        busy;
  logic        done;
  logic        collision;

  sprite_draw dut (
    .clk(clk), .res(res), .hires(hires), .start(start), .x(x), .y(y), .n(n),
    .sprite_addr(sprite_addr), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_rdata(fb_rdata), .fb_we(fb_we), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [7:0]   smem [4096];
  logic [15:0]  fbm [512];
  logic         fb_clear = 1'b0;
  logic [127:0] ref_row [64];
  wr_t          exp_q [$];
  wr_t          mon_e;
  logic         exp_coll;
  logic         clip;
  int           exp_reads;
  int           reads_before;
  int           mem_reads = 0;
  int           total = 0;
  int           bad = 0;

  // Synchronous memories: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= smem[mem_addr];
    if (fb_rd) fb_rdata <= fbm[fb_addr];
    if (fb_clear) begin
      for (int i = 0; i < 512; i++) fbm[i] <= 16'h0000;
    end else if (fb_we) begin
      fbm[fb_addr] <= fb_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h required=%h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd) mem_reads++;
    if (busy) checkOutput("strobe_overlap", 32'($countones({mem_rd, fb_rd, fb_we}) > 1), 32'd0);
    if (fb_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {7'd0, fb_addr, fb_wdata}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("write_addr", 32'(fb_addr), 32'(mon_e.a));
        checkOutput("write_data", 32'(fb_wdata), 32'(mon_e.d));
      end
    end
  end

  // Pixel model: each sprite pixel lands at an absolute screen column/row.
  task automatic computeExpected(input logic h, input int xi, input int yi, input int ni, input logic [11:0] addr);
    int px, py, rows, nbytes, scale, fr, col;
    logic [15:0]  pat;
    logic [11:0]  a;
    logic [127:0] drawn, newr;
    wr_t e;
    px = h ? (xi % 128) : 2 * (xi % 64);
    py = h ? (yi % 64) : 2 * (yi % 32);
    rows = (ni == 0) ? 16 : ni;
    nbytes = (ni == 0 && h) ? 2 : 1;
    scale = h ? 1 : 2;
    exp_coll = 1'b0;
    exp_reads = 0;
    clip = 1'b0;
    for (int sr = 0; sr < rows; sr++) begin
      a = addr + 12'(sr * nbytes);
      pat = (nbytes == 2) ? {smem[a], smem[a + 12'd1]} : {smem[a], 8'h00};
      if (py + sr * scale < 64) exp_reads += nbytes;
      for (int s = 0; s < scale; s++) begin
        fr = py + sr * scale + s;
        if (fr >= 64) begin
          clip = 1'b1;
          continue;
        end
        drawn = '0;
        for (int i = 0; i < nbytes * 8; i++) begin
          if (pat[15 - i]) begin
            for (int k = 0; k < scale; k++) begin
              col = px + i * scale + k;
              if (col < 128) drawn[127 - col] = 1'b1;
              else clip = 1'b1;
            end
          end
        end
        if ((ref_row[fr] & drawn) != '0) exp_coll = 1'b1;
        newr = ref_row[fr] ^ drawn;
        for (int w = 0; w < 8; w++) begin
          if (drawn[127 - 16 * w -: 16] != 16'h0000) begin
            e.a = 9'(fr * 8 + w);
            e.d = newr[127 - 16 * w -: 16];
            exp_q.push_back(e);
          end
        end
        ref_row[fr] = newr;
      end
    end
  endtask

  task automatic applyStimulus(input logic h, input int xi, input int yi, input int ni, input logic [11:0] addr);
    computeExpected(h, xi, yi, ni, addr);
    @(negedge clk);
    reads_before = mem_reads;
    hires = h;
    x = 7'(xi);
    y = 6'(yi);
    n = 4'(ni);
    sprite_addr = addr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finishDraw(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_collision"}, 32'(collision), 32'(exp_coll));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    if (!clip) checkOutput({tag, "_mem_reads"}, 32'(mem_reads - reads_before), 32'(exp_reads));
  endtask

  task automatic clearFb();
    for (int r = 0; r < 64; r++) ref_row[r] = '0;
    @(negedge clk);
    fb_clear = 1'b1;
    @(negedge clk);
    fb_clear = 1'b0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 4096; i++) smem[i] = 8'h00;
    smem[0] = 8'hF0;
    smem[16] = 8'hFF;
    for (int i = 32; i < 35; i++) smem[i] = 8'hFF;
    smem[48] = 8'h80;
    for (int i = 64; i < 96; i++) smem[i] = 8'($urandom_range(0, 255));
    for (int i = 100; i < 116; i++) smem[i] = 8'($urandom_range(0, 255)) | 8'h01;
    for (int i = 4090; i < 4096; i++) smem[i] = 8'($urandom_range(1, 255));

    $display("[TB] reset and idle checks");
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", {26'd0, busy, done, collision, mem_rd, fb_rd, fb_we}, 32'd0);
    checkOutput("reset_addrs", {11'd0, mem_addr, fb_addr}, 32'd0);
    res = 1'b1;
    clearFb();

    hires = 1'b1;
    res = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("start_during_reset", {30'd0, busy, mem_rd}, 32'd0);

    $display("[TB] single byte draw with cycle timing");
    applyStimulus(1'b1, 0, 0, 1, 12'd0);
    checkOutput("c1_fetch", {30'd0, mem_rd, busy}, 32'd3);
    @(negedge clk);
    checkOutput("c2_fwait", {30'd0, mem_rd, fb_rd}, 32'd0);
    @(negedge clk);
    checkOutput("c3_rd", 32'(fb_rd), 32'd1);
    @(negedge clk);
    checkOutput("c4_wr", {6'd0, fb_we, fb_addr, fb_wdata}, {6'd0, 1'b1, 9'd0, 16'hF000});
    @(negedge clk);
    checkOutput("c5_done", {30'd0, done, busy}, 32'd2);
    finishDraw("first");

    applyStimulus(1'b1, 0, 0, 1, 12'd0);
    finishDraw("redraw");
    checkOutput("collision_hold", 32'(collision), 32'd1);

    $display("[TB] word-straddling draw and start ignored while busy");
    clearFb();
    applyStimulus(1'b1, 12, 1, 1, 12'd16);
    start = 1'b1;
    x = 7'd99;
    n = 4'd7;
    repeat (2) @(negedge clk);
    start = 1'b0;
    finishDraw("x12");
    checkOutput("idle_after_done", 32'(busy), 32'd0);
    clearFb();
    applyStimulus(1'b1, 140, 1, 1, 12'd16);
    finishDraw("x140");

    $display("[TB] clipping at right and bottom edges");
    clearFb();
    applyStimulus(1'b1, 124, 62, 3, 12'd32);
    finishDraw("corner");

    $display("[TB] lores and large sprites");
    clearFb();
    applyStimulus(1'b0, 0, 0, 1, 12'd48);
    finishDraw("lores_dot");
    applyStimulus(1'b1, 37, 20, 0, 12'd64);
    finishDraw("hires_large");
    applyStimulus(1'b0, 13, 4, 0, 12'd64);
    finishDraw("lores_large");
    applyStimulus(1'b0, 62, 29, 5, 12'd100);
    finishDraw("lores_clip");
    applyStimulus(1'b1, 70, 55, 0, 12'd4092);
    finishDraw("addr_wrap");

    $display("[TB] reset during a write");
    clearFb();
    applyStimulus(1'b1, 20, 5, 15, 12'd100);
    cnt = 0;
    for (int k = 0; k < 1000 && cnt < 5; k++) begin
      @(negedge clk);
      if (fb_we) cnt++;
    end
    checkOutput("reached_wr", 32'(fb_we), 32'd1);
    res = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_flags", {26'd0, busy, done, collision, mem_rd, fb_rd, fb_we}, 32'd0);
    checkOutput("midreset_addrs", {11'd0, mem_addr, fb_addr}, 32'd0);
    checkOutput("midreset_wdata", 32'(fb_wdata), 32'd0);
    @(negedge clk);
    res = 1'b1;
    exp_q.delete();
    clearFb();
    applyStimulus(1'b1, 0, 0, 1, 12'd0);
    checkOutput("restart_fetch", 32'(mem_rd), 32'd1);
    finishDraw("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
